multimode_ff_bank: RTL and testbench

- WIDTH-channel bank of runtime-selectable flip-flops: D, T, JK or SR, chosen by a shared mode input.
- Each channel provides complementary q/qb outputs. The bank also flags illegal SR inputs and emits a registered pulse when any bit changes.
- It is the parametrised successor to the single-bit toggle flip-flop, for use as a general register or control-state element in lab datapaths and counters.

---
 rtl/multimode_ff_bank.sv | 96 +++++++++
 tb/tb_multimode_ff_bank.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank
//   A bank of WIDTH flip-flops. A shared mode input selects D, T, JK or SR
//   behaviour for every channel at once. Each channel drives complementary
//   q/qb outputs, and both are registered from the same next-state value.
//   The bank also raises a sticky flag on illegal SR inputs. It emits a
//   one-cycle pulse on the cycle after any bit of q changed.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset (overrides everything)
//   en       in   1      clock enable; 0 = all channels hold
//   mode     in   2      00 D, 01 T, 10 JK, 11 SR
//   a        in   WIDTH  D / T / J / S per channel
//   b        in   WIDTH  unused / unused / K / R per channel
//   clr_err  in   1      clears sr_err (a set on the same edge wins)
//   q        out  WIDTH  flip-flop state
//   qb       out  WIDTH  registered complement of q
//   changed  out  1      q changed on the previous edge
//   sr_err   out  1      sticky illegal-SR flag
module multimode_ff_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             changed,
  output logic             sr_err
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  // Bitwise next-state for all four flip-flop types.
  function automatic logic [WIDTH-1:0] ff_next(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] in_a,
    input logic [WIDTH-1:0] in_b
  );
    logic [WIDTH-1:0] legal;
    logic [WIDTH-1:0] nxt;
    nxt   = cur;
    legal = ~(in_a & in_b);
    case (m)
      MODE_D:  nxt = in_a;
      MODE_T:  nxt = cur ^ in_a;
      // J sets a low bit, and a high bit survives unless K clears it.
      MODE_JK: nxt = (in_a & ~cur) | (~in_b & cur);
      // Channels with S=R=1 keep their value. Legal channels follow S/R.
      MODE_SR: nxt = (cur & ~legal) | (legal & (in_a | (cur & ~in_b)));
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  logic [WIDTH-1:0] q_next;
  logic             sr_illegal;

  always_comb begin
    q_next     = ff_next(mode, q, a, b);
    sr_illegal = (mode == MODE_SR) && (|(a & b));
  end

  // Stage boundary: all outputs are registered on this single edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RST_VAL;
      qb      <= ~RST_VAL;
      changed <= 1'b0;
      sr_err  <= 1'b0;
    end else begin
      if (en) begin
        q       <= q_next;
        qb      <= ~q_next;
        changed <= (q_next != q);
      end else begin
        changed <= 1'b0;
      end
      // A new illegal-SR event takes priority over a clear on the same edge.
      if (en && sr_illegal)
        sr_err <= 1'b1;
      else if (clr_err)
        sr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multimode_ff_bank.sv
module tb_multimode_ff_bank;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         clr_err = 1'b0;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         changed;
  logic         sr_err;

  int errors = 0;
  int checks = 0;

  multimode_ff_bank #(.WIDTH(W), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .clr_err(clr_err), .q(q), .qb(qb), .changed(changed), .sr_err(sr_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and let outputs settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic [7:0] va, input logic [7:0] vb, input logic c);
    rst = r; en = e; mode = m; a = va; b = vb; clr_err = c;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0);
    tick();
    tick();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_q: got %h want %h", q, 8'hA5); end
    checks++; if (qb !== 8'h5A) begin errors++; $display("FAIL reset_qb: got %h want %h", qb, 8'h5A); end
    checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b want 0", changed); end
    checks++; if (sr_err !== 1'b0) begin errors++; $display("FAIL reset_sr_err: got %b want 0", sr_err); end
    rst = 1'b0;
    tick();
    checks++; if (q !== 8'h5A) begin errors++; $display("FAIL reset_release_q: got %h want %h", q, 8'h5A); end
    checks++; if (qb !== 8'hA5) begin errors++; $display("FAIL reset_release_qb: got %h want %h", qb, 8'hA5); end
    checks++; if (changed !== 1'b1) begin errors++; $display("FAIL reset_release_changed: got %b want 1", changed); end
  endtask

  task automatic test_toggle();
    logic [7:0] av [5] = '{8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h00};
    logic [1:0] mv [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [7:0] eq [5] = '{8'h00, 8'h0F, 8'h00, 8'h0F, 8'h0F};
    logic       ec [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, mv[i], av[i], 8'h00, 1'b0);
      tick();
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL toggle_q[%0d]: got %h want %h", i, q, eq[i]); end
      checks++; if (qb !== ~eq[i]) begin errors++; $display("FAIL toggle_qb[%0d]: got %h want %h", i, qb, ~eq[i]); end
      checks++; if (changed !== ec[i]) begin errors++; $display("FAIL toggle_changed[%0d]: got %b want %b", i, changed, ec[i]); end
    end
  endtask

  task automatic test_jk();
    logic [7:0] jv [3] = '{8'hF0, 8'hFF, 8'h00};
    logic [7:0] kv [3] = '{8'h0F, 8'hFF, 8'h00};
    logic [7:0] eq [3] = '{8'hF0, 8'h0F, 8'h0F};
    logic       ec [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 2'b10, jv[i], kv[i], 1'b0);
      tick();
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL jk_q[%0d]: got %h want %h", i, q, eq[i]); end
      checks++; if (qb !== ~eq[i]) begin errors++; $display("FAIL jk_qb[%0d]: got %h want %h", i, qb, ~eq[i]); end
      checks++; if (changed !== ec[i]) begin errors++; $display("FAIL jk_changed[%0d]: got %b want %b", i, changed, ec[i]); end
    end
  endtask

  task automatic test_sr();
    // Step 0 writes q=00 in D mode. The remaining steps exercise SR and clr_err.
    logic [1:0] mv [5] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [7:0] sv [5] = '{8'h00, 8'h81, 8'h00, 8'h02, 8'h00};
    logic [7:0] rv [5] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00};
    logic       cv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] eq [5] = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h80};
    logic       ee [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       ec [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, mv[i], sv[i], rv[i], cv[i]);
      tick();
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL sr_q[%0d]: got %h want %h", i, q, eq[i]); end
      checks++; if (qb !== ~eq[i]) begin errors++; $display("FAIL sr_qb[%0d]: got %h want %h", i, qb, ~eq[i]); end
      checks++; if (sr_err !== ee[i]) begin errors++; $display("FAIL sr_err[%0d]: got %b want %b", i, sr_err, ee[i]); end
      checks++; if (changed !== ec[i]) begin errors++; $display("FAIL sr_changed[%0d]: got %b want %b", i, changed, ec[i]); end
    end
  endtask

  task automatic test_enable_d();
    logic       env [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] eq  [3] = '{8'h80, 8'h3C, 8'h3C};
    logic       ec  [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, env[i], 2'b00, 8'h3C, 8'h00, 1'b0);
      tick();
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL en_d_q[%0d]: got %h want %h", i, q, eq[i]); end
      checks++; if (qb !== ~eq[i]) begin errors++; $display("FAIL en_d_qb[%0d]: got %h want %h", i, qb, ~eq[i]); end
      checks++; if (changed !== ec[i]) begin errors++; $display("FAIL en_d_changed[%0d]: got %b want %b", i, changed, ec[i]); end
    end
  endtask

  task automatic test_mid_reset();
    // Step 0 sets sr_err and leaves q at 3C. Steps 1-2 toggle.
    // Step 3 resets during toggling. Steps 4-5 resume toggling from RST_VAL.
    logic       rs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] mv [6] = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [7:0] av [6] = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] bv [6] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] eq [6] = '{8'h3C, 8'hC3, 8'h3C, 8'hA5, 8'h5A, 8'hA5};
    logic       ec [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       ee [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(rs[i], 1'b1, mv[i], av[i], bv[i], 1'b0);
      tick();
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL midrst_q[%0d]: got %h want %h", i, q, eq[i]); end
      checks++; if (qb !== ~eq[i]) begin errors++; $display("FAIL midrst_qb[%0d]: got %h want %h", i, qb, ~eq[i]); end
      checks++; if (changed !== ec[i]) begin errors++; $display("FAIL midrst_changed[%0d]: got %b want %b", i, changed, ec[i]); end
      checks++; if (sr_err !== ee[i]) begin errors++; $display("FAIL midrst_sr_err[%0d]: got %b want %b", i, sr_err, ee[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_jk();
    test_sr();
    test_enable_d();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
